// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, small issue buffer towards decode, PC redirect flush.
// Optional FETCH_STATS_EN adds pop (fetch_cnt) and redirect (flush_cnt) counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [5:0]  Op,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    // state  | meaning
    // S_IDLE | just out of reset, imem responses ignored
    // S_REQ  | request pulse for pc_q on imem
    // S_WAIT | request in flight, waiting for imem_valid
    // S_FULL | buffer full, waiting for decode to pop
    // S_DROP | request in flight for a flushed path, discard its response
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FULL, S_DROP} state_t;

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_after;
    logic [31:0]     word_mem [BUF_DEPTH];
    logic [31:0]     pc_mem   [BUF_DEPTH];
    logic            push, pop, flush;

    assign inst_valid = (cnt_q != '0);
    assign pop        = inst_valid & inst_ready;
    assign flush      = redirect_valid & (state_q != S_IDLE);
    assign push       = (state_q == S_WAIT) & imem_valid & ~redirect_valid;
    assign cnt_after  = cnt_q + CW'(push) - CW'(pop);

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = imem_req ? pc_q : '0;
    assign inst      = inst_valid ? word_mem[rd_ptr_q] : '0;
    assign inst_pc   = inst_valid ? pc_mem[rd_ptr_q] : '0;
    assign Op        = inst[31:26];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            pc_d     = redirect_pc & 32'hFFFF_FFFC;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            // a response landing in the same cycle as the redirect closes out the in-flight request
            case (state_q)
                S_REQ:          state_d = S_DROP;
                S_WAIT, S_DROP: state_d = imem_valid ? S_REQ : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d = cnt_after;
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ:  state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_valid) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = (cnt_after < CW'(BUF_DEPTH)) ? S_REQ : S_FULL;
                    end
                end
                S_FULL: if (pop) state_d = S_REQ;
                S_DROP: if (imem_valid) state_d = S_REQ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // payload needs no reset: outputs are gated by the occupancy count
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= pc_q;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pop)   fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (flush) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: memory responder plus queue-level reference model, decoupled monitor.
module tb_instr_fetch_unit;
    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [5:0]  Op;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt, flush_cnt;
`endif

    instr_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .Op(Op), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_STATS_EN
        , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // reference model / responder state
    logic [31:0] next_addr = RESET_PC;
    bit          pending = 0;
    bit          stale = 0;
    logic [31:0] resp_addr = '0;
    int          wait_cnt = 0;
    int          lat_fixed = 1;
    int          ready_mode = 1;
    int          redir_pct = 0;
    bit          force_redir = 0;
    logic [31:0] force_pc = '0;
    int          qsize5 = 0;
    bit          req_this_cycle = 0;
    logic [31:0] last_req_addr = '0;
    int          n_req = 0;
    int          n_pops = 0;
    int          pops_since_rst = 0;
    int          flushes_since_rst = 0;
    logic [31:0] last_pop_pc = '0;
    logic [31:0] cap_inst = '0;
    logic [5:0]  cap_op = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h8C22_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: drive inputs at the falling edge, update the model 3ns later
    task automatic cycle();
        @(negedge clk);
        qsize5     = exp_q.size();
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(resp_addr);
            end
        end
        case (ready_mode)
            0:       inst_ready = 1'b0;
            1:       inst_ready = 1'b1;
            default: inst_ready = ($urandom_range(0, 9) < 7);
        endcase
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 0;
        end else if (redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
            redirect_valid = 1'b1;
        end
        #3;
        req_this_cycle = 0;
        if (!rst_n) begin
            exp_q.delete();
            next_addr = RESET_PC;
            if (pending) stale = 1;
            if (imem_valid) pending = 0;
            pops_since_rst    = 0;
            flushes_since_rst = 0;
        end else begin
            if (imem_valid) begin
                if (!stale && !redirect_valid) begin
                    exp_q.push_back(exp_t'{pc: resp_addr, word: mem_word(resp_addr)});
                    next_addr = resp_addr + 32'd4;
                end
                pending = 0;
            end
            if (imem_req) begin
                chk("req_addr", imem_addr, next_addr);
                chk("req_slot_free", 32'(qsize5 < BUF_DEPTH), 32'd1);
                chk("one_outstanding", 32'(pending), 32'd0);
                pending        = 1;
                stale          = 0;
                resp_addr      = imem_addr;
                wait_cnt       = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
                req_this_cycle = 1;
                last_req_addr  = imem_addr;
                n_req++;
            end
            if (redirect_valid) begin
                exp_q.delete();
                next_addr = {redirect_pc[31:2], 2'b00};
                if (pending) stale = 1;
                flushes_since_rst++;
            end
        end
    endtask

    task automatic run_until_req(input string name, input int max);
        bit found;
        found = 0;
        for (int i = 0; i < max && !found; i++) begin
            cycle();
            if (req_this_cycle) found = 1;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_imem_req"},   32'(imem_req),   32'd0);
        chk({tag, "_imem_addr"},  imem_addr,       32'd0);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_inst"},       inst,            32'd0);
        chk({tag, "_op"},         32'(Op),         32'd0);
        chk({tag, "_inst_pc"},    inst_pc,         32'd0);
`ifdef FETCH_STATS_EN
        chk({tag, "_fetch_cnt"},  fetch_cnt,       32'd0);
        chk({tag, "_flush_cnt"},  flush_cnt,       32'd0);
`endif
    endtask

    // monitor: every cycle the head must match the oldest expected entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
                if (inst_valid && inst_ready) begin
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("inst", inst, e.word);
                        chk("inst_pc", inst_pc, e.pc);
                        chk("op", 32'(Op), 32'(e.word[31:26]));
                    end
                    n_pops++;
                    pops_since_rst++;
                    last_pop_pc = inst_pc;
                    if (inst_pc == 32'h4) begin
                        cap_inst = inst;
                        cap_op   = Op;
                    end
                end
            end
        end
    end

    initial begin
        int first, p0, n0;

        // reset values, then release with latency-1 memory and decode always ready
        repeat (3) cycle();
        check_reset_outputs("reset");
        ready_mode = 1;
        lat_fixed  = 1;
        rst_n      = 1'b1;
        first      = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (inst_valid && first == 0) first = i;
        end
        // release cycle plus three rising edges
        chk("first_valid_latency", 32'(first), 32'd3);
        p0 = n_pops;
        repeat (20) cycle();
        chk("sustained_rate", 32'(n_pops - p0), 32'd10);
        chk("lw_word", cap_inst, 32'h8C22_0004);
        chk("lw_op", 32'(cap_op), 32'h23);

        // backpressure: buffer fills after BUF_DEPTH requests
        rst_n = 1'b0;
        repeat (2) cycle();
        ready_mode = 0;
        rst_n = 1'b1;
        n0 = n_req;
        repeat (14) cycle();
        chk("full_req_count", 32'(n_req - n0), 32'(BUF_DEPTH));
        chk("full_no_req", 32'(imem_req), 32'd0);
        ready_mode = 1;
        run_until_req("resume_timeout", 10);
        chk("resume_addr", last_req_addr, 32'h8);

        // redirect while waiting for memory
        lat_fixed = 3;
        run_until_req("wait_req_timeout", 10);
        force_redir = 1;
        force_pc    = 32'h40;
        cycle();
        p0 = n_pops;
        for (int i = 0; i < 30 && n_pops == p0; i++) cycle();
        chk("redirect_wait_pop", 32'(n_pops != p0), 32'd1);
        chk("redirect_wait_pc", last_pop_pc, 32'h40);

        // redirect coincident with the response, unaligned target
        lat_fixed = 1;
        run_until_req("coinc_req_timeout", 10);
        force_redir = 1;
        force_pc    = 32'h43;
        cycle();
        run_until_req("coinc_refetch_timeout", 10);
        chk("coinc_refetch_addr", last_req_addr, 32'h40);

        // reset in the middle of S_WAIT; the late response lands in S_IDLE
        lat_fixed = 3;
        run_until_req("rst_req_timeout", 10);
        cycle();
        rst_n = 1'b0;
        cycle();
        check_reset_outputs("midreset");
        cycle();
        rst_n = 1'b1;
        run_until_req("restart_timeout", 10);
        chk("restart_addr", last_req_addr, RESET_PC);

        // randomized traffic
        ready_mode = 2;
        lat_fixed  = 0;
        redir_pct  = 6;
        p0 = n_pops;
        repeat (3000) cycle();
        redir_pct  = 0;
        ready_mode = 1;
        repeat (20) cycle();
        chk("random_progress", 32'(n_pops - p0 >= 300), 32'd1);
`ifdef FETCH_STATS_EN
        chk("fetch_cnt", fetch_cnt, 32'(pops_since_rst));
        chk("flush_cnt", flush_cnt, 32'(flushes_since_rst));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
